// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the byte-wide RAM port controller.
//  - state_t      : controller FSM encoding
//  - SIZE_B/H/W   : load/store size codes (3 is illegal and treated as word)
//  - size_to_bytes: size code -> number of bytes to sequence
//  - is_io        : IO region decode on address bits [17:16]
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Byte count for a size code; the illegal code 3 behaves like a word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // An address is IO when its bits [17:16] match those of the IO base.
  function automatic logic is_io(input logic [1:0] addr_bits, input logic [1:0] base_bits);
    return addr_bits == base_bits;
  endfunction

endpackage

// File: rtl/mc_byte_lane.sv
// mc_byte_lane: combinational byte lane helper for mem_ctrl.
//  wdata    in  32  store word
//  wsel     in  2   byte index to send out for a write
//  wbyte    out 8   selected store byte
//  word_in  in  32  partially assembled read word
//  din      in  8   byte returned by the RAM
//  ins_sel  in  2   lane that receives din
//  word_out out 32  word_in with lane ins_sel replaced by din
module mc_byte_lane (
  input  logic [31:0] wdata,
  input  logic [1:0]  wsel,
  output logic [7:0]  wbyte,
  input  logic [31:0] word_in,
  input  logic [7:0]  din,
  input  logic [1:0]  ins_sel,
  output logic [31:0] word_out
);

  logic [7:0] wlanes [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wlanes[gi] = wdata[8*gi +: 8];
      assign word_out[8*gi +: 8] = (ins_sel == 2'(gi)) ? din : word_in[8*gi +: 8];
    end
  endgenerate

  assign wbyte = wlanes[wsel];

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the single byte-wide RAM port between instruction
// fetch (IF) and load/store (MEM). Multi-byte accesses are sequenced one
// byte per cycle, little-endian; completion is signalled by a one-cycle
// done pulse. MEM wins simultaneous requests.
//
// Optional feature: define MEM_CTRL_IF_CANCEL_EN to let if_cancel abort a
// fetch in flight (or in the cycle it is accepted) without an if_done.
//
// Ports:
//  clk_in, rst_in (async, active-low), rdy_in (0 freezes everything)
//  io_buffer_full       : stalls writes to the IO region
//  if_req/if_addr/if_cancel -> if_done/if_inst
//  mem_req/mem_we/mem_size/mem_addr/mem_wdata -> mem_done/mem_rdata
//  ram_din -> ram_dout/ram_a/ram_wr : external byte RAM/IO bus
//  busy                 : controller not idle
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              busy
);

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [2:0]        nbytes_reg, nbytes_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       data_reg, data_next;
  logic              done_if_reg, done_if_next;
  logic [31:0]       if_inst_reg, if_inst_next;
  logic [31:0]       mem_rdata_reg, mem_rdata_next;

  logic [ADDR_W-1:0] cur_a;
  logic              wr_stall;
  logic              rd_active;
  logic              cancel_hit;
  logic [7:0]        lane_wbyte;
  logic [31:0]       lane_word;
  logic [1:0]        ins_sel;

`ifdef MEM_CTRL_IF_CANCEL_EN
  assign cancel_hit = if_cancel;
`else
  logic unused_if_cancel;
  assign unused_if_cancel = if_cancel;
  assign cancel_hit       = 1'b0;
`endif

  assign cur_a    = base_reg + ADDR_W'(cnt_reg);
  assign wr_stall = is_io(cur_a[17:16], IO_BASE[17:16]) && io_buffer_full;
  // Address phase lasts cnt 0..N-1; cnt==N is the final capture-only cycle.
  assign rd_active = ((state_reg == IF_RD) || (state_reg == MEM_RD)) && (cnt_reg < nbytes_reg);
  // Byte captured in cycle cnt belongs to the address issued at cnt-1.
  assign ins_sel  = cnt_reg[1:0] - 2'd1;

  mc_byte_lane u_lane (
    .wdata    (wdata_reg),
    .wsel     (cnt_reg[1:0]),
    .wbyte    (lane_wbyte),
    .word_in  (data_reg),
    .din      (ram_din),
    .ins_sel  (ins_sel),
    .word_out (lane_word)
  );

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    nbytes_next    = nbytes_reg;
    base_next      = base_reg;
    wdata_next     = wdata_reg;
    data_next      = data_reg;
    done_if_next   = done_if_reg;
    if_inst_next   = if_inst_reg;
    mem_rdata_next = mem_rdata_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = 3'd0;
        if (mem_req) begin
          state_next   = mem_we ? MEM_WR : MEM_RD;
          nbytes_next  = size_to_bytes(mem_size);
          base_next    = mem_addr;
          wdata_next   = mem_wdata;
          data_next    = 32'd0;
          done_if_next = 1'b0;
        end else if (if_req && !cancel_hit) begin
          state_next   = IF_RD;
          nbytes_next  = 3'd4;
          base_next    = if_addr;
          data_next    = 32'd0;
          done_if_next = 1'b1;
        end
      end

      IF_RD, MEM_RD: begin
        if ((state_reg == IF_RD) && cancel_hit) begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end else begin
          if (cnt_reg != 3'd0) begin
            data_next = lane_word;
          end
          if (cnt_reg == nbytes_reg) begin
            state_next = DONE;
            cnt_next   = 3'd0;
            if (state_reg == IF_RD) begin
              if_inst_next = lane_word;
            end else begin
              mem_rdata_next = lane_word;
            end
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end

      MEM_WR: begin
        // A full UART buffer holds the IO byte; it is retried each cycle.
        if (!wr_stall) begin
          if (cnt_reg == nbytes_reg - 3'd1) begin
            state_next = DONE;
            cnt_next   = 3'd0;
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      nbytes_reg    <= 3'd0;
      base_reg      <= '0;
      wdata_reg     <= 32'd0;
      data_reg      <= 32'd0;
      done_if_reg   <= 1'b0;
      if_inst_reg   <= 32'd0;
      mem_rdata_reg <= 32'd0;
    end else if (rdy_in) begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      nbytes_reg    <= nbytes_next;
      base_reg      <= base_next;
      wdata_reg     <= wdata_next;
      data_reg      <= data_next;
      done_if_reg   <= done_if_next;
      if_inst_reg   <= if_inst_next;
      mem_rdata_reg <= mem_rdata_next;
    end
  end

  // The address is parked at 0 outside real byte transfers (including a
  // stalled IO write) so IO locations are never read speculatively.
  assign ram_a     = (rd_active || ((state_reg == MEM_WR) && !wr_stall)) ? cur_a : '0;
  assign ram_wr    = rdy_in && (state_reg == MEM_WR) && !wr_stall;
  assign ram_dout  = (state_reg == MEM_WR) ? lane_wbyte : 8'd0;
  assign if_done   = (state_reg == DONE) && done_if_reg;
  assign mem_done  = (state_reg == DONE) && !done_if_reg;
  assign if_inst   = if_inst_reg;
  assign mem_rdata = mem_rdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a byte RAM/IO model.
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        io_buffer_full = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_cancel = 1'b0;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din = 8'd0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .io_buffer_full (io_buffer_full),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_cancel      (if_cancel),
    .if_done        (if_done),
    .if_inst        (if_inst),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_size       (mem_size),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_done       (mem_done),
    .mem_rdata      (mem_rdata),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr),
    .busy           (busy)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- RAM / IO model (frozen with rdy_in, reloaded in reset)
  logic [7:0]  ram [0:1023];
  int          io_wr_cnt = 0;
  int          io_rd_cnt = 0;
  logic [7:0]  io_last = 8'd0;
  logic [31:0] wr_log_a[$];
  logic [7:0]  wr_log_d[$];
  logic [31:0] rd_log[$];

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h00;
      32'h103: return 8'h00;
      32'h200: return 8'h78;
      32'h201: return 8'h56;
      32'h202: return 8'h34;
      32'h203: return 8'h12;
      default: return 8'(i);
    endcase
  endfunction

  always @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(i);
      ram_din <= 8'd0;
    end else if (rdy_in) begin
      if (ram_wr) begin
        wr_log_a.push_back(ram_a);
        wr_log_d.push_back(ram_dout);
        if (ram_a[17:16] == 2'b11) begin
          io_wr_cnt <= io_wr_cnt + 1;
          io_last   <= ram_dout;
        end else begin
          ram[ram_a[9:0]] <= ram_dout;
        end
      end else begin
        if (ram_a[17:16] == 2'b11) ram_din <= 8'hC3;
        else                       ram_din <= ram[ram_a[9:0]];
        if (busy && ram_a != 32'd0) begin
          rd_log.push_back(ram_a);
          if (ram_a[17:16] == 2'b11) io_rd_cnt <= io_rd_cnt + 1;
        end
      end
    end
  end

  // ---------------- helpers
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mem_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int lat, output logic ok);
    mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    lat = 0; ok = 1'b0; rdata = 32'hx;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      lat++;
      if (mem_done) begin
        ok = 1'b1;
        rdata = mem_rdata;
        mem_req = 1'b0;
      end
    end
    mem_req = 1'b0;
  endtask

  task automatic wait_mem(output logic [31:0] rdata, output logic ok);
    ok = 1'b0; rdata = 32'hx;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (mem_done) begin
        ok = 1'b1;
        rdata = mem_rdata;
        mem_req = 1'b0;
      end
    end
    mem_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence
  initial begin
    logic [31:0] rd;
    logic        ok;
    int          lat;
    int          mem_ord, if_ord, ord, base_cnt, pulses;
    logic [31:0] exp_rd [8];

    // Reset state
    rst_in = 1'b0;
    tick(); tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check("rst_ram_a", ram_a, 32'd0);
    check("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    check("rst_data", if_inst | mem_rdata, 32'd0);
    rst_in = 1'b1;
    tick();

    // IF only: 6 cycles from request to if_done, single pulse
    if_addr = 32'h100; if_req = 1'b1; lat = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(); lat++;
      if (if_done) begin ok = 1'b1; if_req = 1'b0; end
    end
    if_req = 1'b0;
    check("if_done_seen", {31'd0, ok}, 32'd1);
    check("if_latency", lat, 6);
    check("if_inst", if_inst, 32'h00000513);
    tick();
    check("if_single_pulse", {31'd0, if_done}, 32'd0);
    check("if_idle_after", {31'd0, busy}, 32'd0);

    // Tie: load wins, then fetch, no interleaving
    rd_log.delete();
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h100;
    mem_ord = -1; if_ord = -1; ord = 0; rd = 32'hx;
    for (int i = 0; i < 60 && (mem_ord < 0 || if_ord < 0); i++) begin
      tick();
      if (mem_done) begin mem_ord = ord; ord++; rd = mem_rdata; mem_req = 1'b0; end
      if (if_done)  begin if_ord = ord; ord++; if_req = 1'b0; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    check("tie_mem_first", mem_ord, 0);
    check("tie_if_second", if_ord, 1);
    check("tie_lw_data", rd, 32'h12345678);
    check("tie_if_data", if_inst, 32'h00000513);
    exp_rd = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h100, 32'h101, 32'h102, 32'h103};
    check("tie_rd_count", rd_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < rd_log.size()) check($sformatf("tie_rd_addr%0d", k), rd_log[k], exp_rd[k]);
    end
    tick();

    // Store half 0xBEEF at 0x201, then loads
    wr_log_a.delete(); wr_log_d.delete();
    mem_op(1'b1, 2'd1, 32'h201, 32'h0000BEEF, rd, lat, ok);
    check("sh_done", {31'd0, ok}, 32'd1);
    check("sh_latency", lat, 3);
    check("sh_wr_count", wr_log_a.size(), 2);
    if (wr_log_a.size() >= 2) begin
      check("sh_wr0", {wr_log_a[0][23:0], wr_log_d[0]}, 32'h000201EF);
      check("sh_wr1", {wr_log_a[1][23:0], wr_log_d[1]}, 32'h000202BE);
    end
    tick();
    check("sh_single_pulse", {31'd0, mem_done}, 32'd0);
    mem_op(1'b0, 2'd0, 32'h202, 32'd0, rd, lat, ok);
    check("lb_data", rd, 32'h000000BE);
    check("lb_latency", lat, 3);
    tick();
    mem_op(1'b0, 2'd2, 32'h200, 32'd0, rd, lat, ok);
    check("lw_after_sh", rd, 32'h12BEEF78);
    tick();

    // IO write held off by a full buffer for 3 cycles
    base_cnt = io_wr_cnt;
    io_buffer_full = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h30000; mem_wdata = 32'h0000005A;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("io_stall_wr%0d", k), {31'd0, ram_wr}, 32'd0);
      check($sformatf("io_stall_busy%0d", k), {31'd0, busy}, 32'd1);
    end
    check("io_no_write_yet", io_wr_cnt - base_cnt, 0);
    io_buffer_full = 1'b0;
    wait_mem(rd, ok);
    check("io_wr_done", {31'd0, ok}, 32'd1);
    check("io_wr_once", io_wr_cnt - base_cnt, 1);
    check("io_wr_data", {24'd0, io_last}, 32'h5A);
    tick();

    // IO read issued once
    base_cnt = io_rd_cnt;
    mem_op(1'b0, 2'd0, 32'h30000, 32'd0, rd, lat, ok);
    check("io_rd_data", rd, 32'h000000C3);
    tick();
    check("io_rd_once", io_rd_cnt - base_cnt, 1);

    // rdy_in low for 4 cycles mid word read
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h200;
    tick(); tick();
    rdy_in = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mem_done) pulses++;
    end
    check("rdy_frozen_busy", {31'd0, busy}, 32'd1);
    check("rdy_frozen_no_done", pulses, 0);
    rdy_in = 1'b1;
    wait_mem(rd, ok);
    check("rdy_word", rd, 32'h12BEEF78);
    tick();

    // rdy_in low blocks ram_wr combinationally
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0; mem_addr = 32'h300; mem_wdata = 32'h77;
    tick();
    rdy_in = 1'b0;
    #1;
    check("rdy_wr_forced0", {31'd0, ram_wr}, 32'd0);
    tick();
    check("rdy_wr_still0", {31'd0, ram_wr}, 32'd0);
    rdy_in = 1'b1;
    #1;
    check("rdy_wr_resume", {31'd0, ram_wr}, 32'd1);
    wait_mem(rd, ok);
    tick();
    mem_op(1'b0, 2'd0, 32'h300, 32'd0, rd, lat, ok);
    check("rdy_sb_readback", rd, 32'h00000077);
    tick();

    // Reset mid-read: back to IDLE, no done pulse
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h100;
    tick(); tick(); tick();
    rst_in = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_rdata", mem_rdata, 32'd0);
    mem_req = 1'b0;
    tick();
    rst_in = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (mem_done || if_done) pulses++;
    end
    check("rstmid_no_done", pulses, 0);

    // Fetch cancel at byte 2
    if_addr = 32'h100; if_req = 1'b1;
    tick(); tick(); tick();
    if_cancel = 1'b1;
`ifdef MEM_CTRL_IF_CANCEL_EN
    if_req = 1'b0;
    tick();
    if_cancel = 1'b0;
    check("cancel_idle", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (if_done) pulses++;
    end
    check("cancel_no_done", pulses, 0);
`else
    tick();
    if_cancel = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (if_done) begin ok = 1'b1; if_req = 1'b0; end
      else tick();
    end
    if_req = 1'b0;
    check("nocancel_done", {31'd0, ok}, 32'd1);
    check("nocancel_inst", if_inst, 32'h00000513);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
